// File: rtl/hpgp_turbo_enc.sv
// hpgp_turbo_enc
//   Duo-binary turbo encoder stage. It sits directly after the HPGP turbo
//   interleaver and takes two di-bit streams each cycle:
//     - the natural-order systematic pair (din_sys)
//     - the interleaved pair (din_itl)
//   Two identical 8-state recursive constituent encoders run in lock-step,
//   one per stream. Each accepted pair produces, one cycle later:
//     - the systematic pair
//     - one parity bit per encoder
//     - block framing (first/last)
//   After the last pair of a block, the final encoder states are reported.
//
// Ports
//   clk        rising-edge system clock
//   n_rst      asynchronous active-low reset
//   pb_size    block size code, sampled on the first pair of a block:
//                0 -> 64, 1 -> 544, 2 -> 2080, 3 -> 8 pairs
//   din_sys    systematic pair {u1,u2}
//   din_itl    interleaved pair {v1,v2}
//   din_vld    both input pairs valid this cycle
//   dout_sys   registered copy of din_sys
//   dout_par   {p,q}: p from encoder 1 (systematic), q from encoder 2
//   dout_vld   dout_sys/dout_par valid
//   dout_first first pair of the block (qualified by dout_vld)
//   dout_last  last pair of the block (qualified by dout_vld)
//   end_st1    encoder-1 final state {s1,s2,s3}; holds until the next end_vld
//   end_st2    encoder-2 final state; holds until the next end_vld
//   end_vld    one-cycle pulse when a block has finished
//   busy       high while a block is in progress (RUN)
//
// Handshake: din_vld is a pure valid qualifier. There is no ready signal,
// and every pair presented in IDLE or RUN is consumed on that edge. A pair
// presented during the single DONE cycle is dropped. Upstream leaves at
// least one idle cycle between blocks, so this drop never hits real data.
module hpgp_turbo_enc #(
  parameter int CNT_W = 12
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic [1:0] din_sys,
  input  logic [1:0] din_itl,
  input  logic       din_vld,
  output logic [1:0] dout_sys,
  output logic [1:0] dout_par,
  output logic       dout_vld,
  output logic       dout_first,
  output logic       dout_last,
  output logic [2:0] end_st1,
  output logic [2:0] end_st2,
  output logic       end_vld,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         st1_q, st2_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;

  logic               accept;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   len_dec;
  logic [CNT_W-1:0]   len_cur;
  logic               last_hit;
  logic [3:0]         step1, step2;

  // One constituent-encoder step.
  // Returns {parity, next_state}; state is {s1,s2,s3}.
  // Parity uses the pre-update state.
  function automatic logic [3:0] enc_step(input logic       a,
                                          input logic       b,
                                          input logic [2:0] s);
    logic fb;
    logic par;
    fb  = a ^ b ^ s[1] ^ s[0];
    par = fb ^ s[2] ^ s[0];
    return {par, fb, s[2] ^ b, s[1] ^ b};
  endfunction

  always_comb begin
    len_dec = CNT_W'(8);
    case (pb_size)
      2'd0:    len_dec = CNT_W'(64);
      2'd1:    len_dec = CNT_W'(544);
      2'd2:    len_dec = CNT_W'(2080);
      default: len_dec = CNT_W'(8);
    endcase
  end

  // In IDLE the incoming pair is pair 1 of a new block. Its length comes
  // straight from pb_size, because len_q is only loaded on that same edge.
  assign accept   = din_vld && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign cnt_inc  = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign len_cur  = (state_q == ST_IDLE) ? len_dec : len_q;
  assign last_hit = accept && (cnt_inc == len_cur);

  assign step1 = enc_step(din_sys[1], din_sys[0], st1_q);
  assign step2 = enc_step(din_itl[1], din_itl[0], st2_q);

  assign busy = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (din_vld) state_d = ST_RUN;
      ST_RUN:  if (last_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st1_q      <= 3'b000;
      st2_q      <= 3'b000;
      cnt_q      <= '0;
      len_q      <= '0;
      dout_sys   <= 2'b00;
      dout_par   <= 2'b00;
      dout_vld   <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      end_st1    <= 3'b000;
      end_st2    <= 3'b000;
      end_vld    <= 1'b0;
    end else begin
      dout_vld   <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      end_vld    <= 1'b0;
      if (accept) begin
        dout_sys   <= din_sys;
        dout_par   <= {step1[3], step2[3]};
        dout_vld   <= 1'b1;
        dout_first <= (state_q == ST_IDLE);
        dout_last  <= last_hit;
        st1_q      <= step1[2:0];
        st2_q      <= step2[2:0];
        cnt_q      <= cnt_inc;
        if (state_q == ST_IDLE) len_q <= len_dec;
      end else if (state_q == ST_DONE) begin
        // Report the final states, then clear so the next block starts at 000.
        end_vld <= 1'b1;
        end_st1 <= st1_q;
        end_st2 <= st2_q;
        st1_q   <= 3'b000;
        st2_q   <= 3'b000;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hpgp_turbo_enc.sv
module tb_hpgp_turbo_enc;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] pb_size = 2'd3;
  logic [1:0] din_sys = 2'b00;
  logic [1:0] din_itl = 2'b00;
  logic       din_vld = 1'b0;
  logic [1:0] dout_sys, dout_par;
  logic       dout_vld, dout_first, dout_last;
  logic [2:0] end_st1, end_st2;
  logic       end_vld, busy;

  int checks = 0;
  int failures = 0;

  // Output scoreboard entry: {sys[1:0], par[1:0], first, last}.
  logic [5:0] exp_q[$];
  // End-of-block entry: {end_st1, end_st2}.
  logic [5:0] end_q[$];
  // Parity pairs seen, in output order.
  logic [1:0] obs_par[$];

  // Reference model state.
  logic [2:0] m1, m2;
  int         m_cnt;
  int         m_len;

  hpgp_turbo_enc #(.CNT_W(12)) dut (
    .clk(clk), .n_rst(n_rst), .pb_size(pb_size),
    .din_sys(din_sys), .din_itl(din_itl), .din_vld(din_vld),
    .dout_sys(dout_sys), .dout_par(dout_par), .dout_vld(dout_vld),
    .dout_first(dout_first), .dout_last(dout_last),
    .end_st1(end_st1), .end_st2(end_st2), .end_vld(end_vld), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Encoder written bit by bit. The parity reduces to a^b^s1^s2.
  function automatic logic [3:0] model_step(input logic [1:0] ab,
                                            input logic [2:0] st);
    logic a, b, s1, s2, s3, fb, p;
    a  = ab[1];
    b  = ab[0];
    s1 = st[2];
    s2 = st[1];
    s3 = st[0];
    fb = a ^ b ^ s2 ^ s3;
    p  = a ^ b ^ s1 ^ s2;
    return {p, fb, s1 ^ b, s2 ^ b};
  endfunction

  function automatic int size_of(input logic [1:0] code);
    case (code)
      2'd0:    return 64;
      2'd1:    return 544;
      2'd2:    return 2080;
      default: return 8;
    endcase
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_pair(input logic [1:0] s, input logic [1:0] i);
    logic [3:0] r1, r2;
    logic       first, last;
    din_sys = s;
    din_itl = i;
    din_vld = 1'b1;
    if (m_cnt == 0) m_len = size_of(pb_size);
    first = (m_cnt == 0);
    r1 = model_step(s, m1);
    r2 = model_step(i, m2);
    m_cnt++;
    last = (m_cnt == m_len);
    exp_q.push_back({s, r1[3], r2[3], first, last});
    m1 = r1[2:0];
    m2 = r2[2:0];
    if (last) begin
      end_q.push_back({m1, m2});
      m1 = 3'b000;
      m2 = 3'b000;
      m_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m1 = 3'b000;
    m2 = 3'b000;
    m_cnt = 0;
    m_len = 8;
    exp_q.delete();
    end_q.delete();
    obs_par.delete();
  endtask

  // Bounded wait until every expected output and end report has arrived.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || end_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || end_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain: pending out=%0d end=%0d, expected 0/0",
               name, exp_q.size(), end_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (n_rst && dout_vld) begin
      obs_par.push_back(dout_par);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got sys=%b par=%b first=%b last=%b, none expected",
                 dout_sys, dout_par, dout_first, dout_last);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({dout_sys, dout_par, dout_first, dout_last} !== e) begin
          failures++;
          $display("FAIL out_pair: got {sys,par,first,last}=%b expected %b",
                   {dout_sys, dout_par, dout_first, dout_last}, e);
        end
      end
    end
    if (n_rst && end_vld) begin
      checks++;
      if (end_q.size() == 0) begin
        failures++;
        $display("FAIL end_unexpected: got end_vld st1=%b st2=%b, none expected",
                 end_st1, end_st2);
      end else begin
        logic [5:0] e;
        e = end_q.pop_front();
        if ({end_st1, end_st2} !== e) begin
          failures++;
          $display("FAIL end_state: got {st1,st2}=%b expected %b", {end_st1, end_st2}, e);
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({dout_sys, dout_par, dout_vld, dout_first, dout_last, end_st1, end_st2, end_vld, busy}
        !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {dout_sys, dout_par, dout_vld, dout_first, dout_last,
                end_st1, end_st2, end_vld, busy});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_impulse_par(input string name);
    logic [7:0] p_exp;
    p_exp = 8'b11110010;
    checks++;
    if (obs_par.size() != 8) begin
      failures++;
      $display("FAIL %s count: got %0d pairs expected 8", name, obs_par.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs_par[k] !== {p_exp[7-k], 1'b0}) begin
          failures++;
          $display("FAIL %s par[%0d]: got %b expected %b", name, k, obs_par[k], {p_exp[7-k], 1'b0});
        end
      end
    end
    checks++;
    if (end_st1 !== 3'b100 || end_st2 !== 3'b000) begin
      failures++;
      $display("FAIL %s end_st: got %b/%b expected 100/000", name, end_st1, end_st2);
    end
  endtask

  task automatic test_zero_block();
    pb_size = 2'd3;
    obs_par.delete();
    for (int k = 0; k < 8; k++) begin
      drive_pair(2'b00, 2'b00);
      checks++;
      if (busy !== 1'b1 && k < 7) begin
        failures++;
        $display("FAIL zero_busy: got %b expected 1 at pair %0d", busy, k + 1);
      end
    end
    idle(1);
    wait_drain("zero");
    checks++;
    if (end_st1 !== 3'b000 || end_st2 !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_end: got st=%b/%b busy=%b expected 000/000 busy=0", end_st1, end_st2, busy);
    end
  endtask

  task automatic test_impulse();
    pb_size = 2'd3;
    obs_par.delete();
    drive_pair(2'b10, 2'b00);
    for (int k = 0; k < 7; k++) drive_pair(2'b00, 2'b00);
    idle(1);
    wait_drain("impulse");
    check_impulse_par("impulse");
  endtask

  task automatic test_gapped();
    pb_size = 2'd3;
    obs_par.delete();
    drive_pair(2'b10, 2'b00);
    drive_pair(2'b00, 2'b00);
    din_vld = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      checks++;
      if (dout_vld !== 1'b0 || dout_sys !== 2'b00 || dout_par !== 2'b10) begin
        failures++;
        $display("FAIL gap_hold: got vld=%b sys=%b par=%b expected 0/00/10", dout_vld, dout_sys, dout_par);
      end
    end
    for (int k = 0; k < 6; k++) drive_pair(2'b00, 2'b00);
    idle(1);
    wait_drain("gapped");
    check_impulse_par("gapped");
  endtask

  task automatic test_back_to_back();
    pb_size = 2'd3;
    drive_pair(2'b10, 2'b00);
    for (int k = 0; k < 7; k++) drive_pair(2'b00, 2'b00);
    idle(1);
    obs_par.delete();
    for (int k = 0; k < 8; k++) drive_pair(2'b00, 2'b00);
    idle(1);
    wait_drain("b2b");
    for (int k = 0; k < obs_par.size(); k++) begin
      checks++;
      if (obs_par[k] !== 2'b00) begin
        failures++;
        $display("FAIL b2b_par[%0d]: got %b expected 00", k, obs_par[k]);
      end
    end
  endtask

  task automatic test_sizes();
    logic [1:0] codes[3];
    codes[0] = 2'd0;
    codes[1] = 2'd1;
    codes[2] = 2'd2;
    for (int c = 0; c < 3; c++) begin
      pb_size = codes[c];
      for (int k = 0; k < size_of(codes[c]); k++) begin
        drive_pair(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        if (k == 10) pb_size = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
      end
      idle(2);
      wait_drain("sizes");
    end
  endtask

  task automatic test_reset_mid_block();
    pb_size = 2'd3;
    drive_pair(2'b10, 2'b00);
    for (int k = 0; k < 3; k++) drive_pair(2'b01, 2'b11);
    din_vld = 1'b0;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({dout_sys, dout_par, dout_vld, dout_first, dout_last, end_vld, busy} !== 9'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got %b expected all zero",
               {dout_sys, dout_par, dout_vld, dout_first, dout_last, end_vld, busy});
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    idle(12);
    test_impulse();
  endtask

  // ---------------- sequence ----------------
  initial begin
    m1 = 3'b000;
    m2 = 3'b000;
    m_cnt = 0;
    m_len = 8;
    @(negedge clk);
    test_reset();
    test_zero_block();
    idle(2);
    test_impulse();
    idle(2);
    test_gapped();
    idle(2);
    test_back_to_back();
    idle(2);
    test_sizes();
    idle(2);
    test_reset_mid_block();
    idle(3);
    checks++;
    if (exp_q.size() != 0 || end_q.size() != 0) begin
      failures++;
      $display("FAIL final_queues: got out=%0d end=%0d expected 0/0", exp_q.size(), end_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
